// File: rtl/vline_pkg.sv
// Shared constants for the vertical-line motion controller: FSM state encoding,
// screen Y limits, direction encoding and a saturating counter helper.
package vline_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_STEP   = 3'd4,
    S_PARKED = 3'd5
  } vline_state_e;

  localparam int unsigned Y_MIN  = 18;
  localparam int unsigned Y_MAX  = 487;
  localparam logic        DIR_UP = 1'b1;
  localparam logic        DIR_DW = 1'b0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vline_motion_ctrl_if.sv
// Control/strobe bundle between the motion controller and its surroundings
// (frame timing, start/halt, counter limit flags in; counter strobes and status out).
interface vline_motion_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       halt;
  logic       dir_in;
  logic       at_top;
  logic       at_bot;
  logic       UP;
  logic       DW;
  logic       LD;
  logic       moving;
  logic       dir;
  logic [7:0] bounce_cnt;

  modport master (
    output frame_tick, start, halt, dir_in, at_top, at_bot,
    input  UP, DW, LD, moving, dir, bounce_cnt
  );

  modport slave (
    input  frame_tick, start, halt, dir_in, at_top, at_bot,
    output UP, DW, LD, moving, dir, bounce_cnt
  );
endinterface

// File: rtl/vline_frame_div.sv
// 8-bit frame_tick divider: fire pulses on the tick that completes FRAME_DIV ticks.
// clr holds the count at zero whenever the controller is not waiting.
module vline_frame_div #(
  parameter int unsigned FRAME_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic fire
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    fire  = tick && (cnt_q == 8'(FRAME_DIV - 1));
    cnt_d = cnt_q;
    if (clr || fire) cnt_d = 8'd0;
    else if (tick)   cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vline_motion_ctrl.sv
// Vertical-line motion controller: converts frame ticks and start/halt into UP/DW/LD
// strobes for the Y counter. Define VLINE_BOUNCE_EN to reverse at screen edges instead of parking.
module vline_motion_ctrl
  import vline_pkg::*;
#(
  parameter int unsigned FRAME_DIV = 2,
  parameter int unsigned STEP      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  vline_motion_ctrl_if.slave   bus
);

  vline_state_e state_q, state_d;
  logic [3:0]   step_q, step_d;
  logic         dir_q, dir_d;
  logic [7:0]   bounce_q, bounce_d;
  logic         ld_q, ld_d;
  logic         moving_q, moving_d;

  logic halt_act, both_hit, limit_hit, step_last, fire, strobe_ok;

  assign halt_act  = bus.halt && (state_q != S_IDLE);
  assign both_hit  = bus.at_top && bus.at_bot;
  assign limit_hit = (dir_q == DIR_UP) ? bus.at_top : bus.at_bot;
  assign step_last = (step_q == 4'(STEP - 1));

  vline_frame_div #(.FRAME_DIV(FRAME_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q != S_WAIT) || halt_act),
    .tick  (bus.frame_tick && (state_q == S_WAIT) && !halt_act),
    .fire  (fire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      step_q   <= 4'd0;
      dir_q    <= 1'b0;
      bounce_q <= 8'd0;
      ld_q     <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
      ld_q     <= ld_d;
      moving_q <= moving_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    dir_d    = dir_q;
    bounce_d = bounce_q;
    if (halt_act) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (bus.start) state_d = S_LOAD;
        S_LOAD: begin
          dir_d    = bus.dir_in;
          bounce_d = 8'd0;
          state_d  = S_ARM;
        end
        S_ARM:    state_d = S_WAIT;
        S_WAIT: begin
          if (fire) begin
            step_d  = 4'd0;
            state_d = S_STEP;
          end
        end
        S_STEP: begin
          step_d = step_q + 4'd1;
          if (both_hit) begin
            state_d = S_PARKED;
          end else if (limit_hit) begin
`ifdef VLINE_BOUNCE_EN
            // The reversal cycle consumes a step; remaining steps go the other way.
            dir_d    = ~dir_q;
            bounce_d = sat_inc8(bounce_q);
            if (step_last) state_d = S_WAIT;
`else
            state_d = S_PARKED;
`endif
          end else if (step_last) begin
            state_d = S_WAIT;
          end
        end
        S_PARKED: if (bus.start) state_d = S_LOAD;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are gated by the live limit flags and halt so no move is issued at the edge.
  always_comb begin
    strobe_ok = (state_q == S_STEP) && !halt_act && !both_hit && !limit_hit;
    ld_d      = (state_d == S_LOAD);
    moving_d  = (state_d == S_ARM) || (state_d == S_WAIT) || (state_d == S_STEP);
  end

  assign bus.UP         = strobe_ok && (dir_q == DIR_UP);
  assign bus.DW         = strobe_ok && (dir_q == DIR_DW);
  assign bus.LD         = ld_q;
  assign bus.moving     = moving_q;
  assign bus.dir        = dir_q;
  assign bus.bounce_cnt = bounce_q;

endmodule

// File: tb/tb_vline_motion_ctrl.sv
// Directed bench for vline_motion_ctrl: three instances (FRAME_DIV/STEP = 2/1, 1/4, 1/8),
// each driving a behavioural Y counter, followed by a random soak on the strobe invariants.
module tb_vline_motion_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vline_motion_ctrl_if ia ();
  vline_motion_ctrl_if ib ();
  vline_motion_ctrl_if ic ();

  vline_motion_ctrl #(.FRAME_DIV(2), .STEP(1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  vline_motion_ctrl #(.FRAME_DIV(1), .STEP(4)) dut_b (.clk(clk), .reset(reset), .bus(ib));
  vline_motion_ctrl #(.FRAME_DIV(1), .STEP(8)) dut_c (.clk(clk), .reset(reset), .bus(ic));

  logic [15:0] y_a, y_b, y_c, sw_a, sw_b, sw_c;
  logic        frc_c;

  always_comb begin
    ia.at_top = (y_a == 16'd487);
    ia.at_bot = (y_a == 16'd18);
    ib.at_top = (y_b == 16'd487);
    ib.at_bot = (y_b == 16'd18);
    ic.at_top = (y_c == 16'd487) || frc_c;
    ic.at_bot = (y_c == 16'd18)  || frc_c;
  end

  always @(posedge clk) begin
    if (reset)      y_a <= 16'd0;
    else if (ia.LD) y_a <= sw_a;
    else if (ia.UP) y_a <= y_a + 16'd1;
    else if (ia.DW) y_a <= y_a - 16'd1;
  end
  always @(posedge clk) begin
    if (reset)      y_b <= 16'd0;
    else if (ib.LD) y_b <= sw_b;
    else if (ib.UP) y_b <= y_b + 16'd1;
    else if (ib.DW) y_b <= y_b - 16'd1;
  end
  always @(posedge clk) begin
    if (reset)      y_c <= 16'd0;
    else if (ic.LD) y_c <= sw_c;
    else if (ic.UP) y_c <= y_c + 16'd1;
    else if (ic.DW) y_c <= y_c - 16'd1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic ng();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ia.frame_tick = 0; ia.start = 0; ia.halt = 0; ia.dir_in = 0;
    ib.frame_tick = 0; ib.start = 0; ib.halt = 0; ib.dir_in = 0;
    ic.frame_tick = 0; ic.start = 0; ic.halt = 0; ic.dir_in = 0;
    sw_a = 16'd0; sw_b = 16'd0; sw_c = 16'd0; frc_c = 1'b0;

    // 1: reset held while start and frame_tick are active
    ia.start = 1; ib.start = 1; ic.start = 1;
    for (int i = 0; i < 4; i++) begin
      nx();
      ia.frame_tick = i[0]; ib.frame_tick = i[0]; ic.frame_tick = i[0];
      ng();
      chk("rst_a_outs", {ia.UP, ia.DW, ia.LD, ia.moving, ia.dir}, 0);
      chk("rst_b_outs", {ib.UP, ib.DW, ib.LD, ib.moving, ib.dir}, 0);
      chk("rst_c_bounce", ic.bounce_cnt, 0);
    end
    nx();
    reset = 0;
    ia.start = 0; ib.start = 0; ic.start = 0;
    ia.frame_tick = 0; ib.frame_tick = 0; ic.frame_tick = 0;
    ng();
    chk("idle_a_moving", ia.moving, 0);
    chk("idle_a_ld", ia.LD, 0);

    // 2: FRAME_DIV=2, STEP=1, going up
    nx(); ia.start = 1; ia.dir_in = 1; sw_a = 16'd100; ng();
    nx(); ia.start = 0; ng();
    chk("a_ld_pulse", ia.LD, 1);
    chk("a_load_not_moving", ia.moving, 0);
    nx(); ng();
    chk("a_ld_once", ia.LD, 0);
    chk("a_arm_moving", ia.moving, 1);
    chk("a_dir_latched", ia.dir, 1);
    nx(); ng();
    chk("a_y_loaded", y_a, 100);
    nx(); ia.frame_tick = 1; ng(); chk("a_tick1_no_up", ia.UP, 0);
    nx(); ia.frame_tick = 0; ng(); chk("a_gap_no_up", ia.UP, 0);
    nx(); ia.frame_tick = 1; ng(); chk("a_tick2_no_up", ia.UP, 0);
    nx(); ia.frame_tick = 1; ng();
    chk("a_up_after_tick2", {ia.UP, ia.DW}, 2'b10);
    nx(); ia.frame_tick = 1; ng();
    chk("a_up_single", ia.UP, 0);
    chk("a_y_101", y_a, 101);
    nx(); ia.frame_tick = 1; ng(); chk("a_step_tick_dropped", ia.UP, 0);
    nx(); ia.frame_tick = 0; ng(); chk("a_up_second", ia.UP, 1);
    nx(); ng();
    chk("a_y_102", y_a, 102);
    chk("a_still_moving", ia.moving, 1);

    // 3/4: STEP=4, FRAME_DIV=1, load 485 and move up into the top edge
    nx(); ib.start = 1; ib.dir_in = 1; sw_b = 16'd485; ng();
    nx(); ib.start = 0; ng(); chk("b_ld_pulse", ib.LD, 1);
    nx(); ng(); chk("b_y_485", y_b, 485);
    nx(); ib.frame_tick = 1; ng(); chk("b_wait_no_up", ib.UP, 0);
    nx(); ib.frame_tick = 0; ng(); chk("b_up1", ib.UP, 1);
    nx(); ng(); chk("b_up2", ib.UP, 1);
    nx(); ng();
    chk("b_limit_no_strobe", {ib.UP, ib.DW}, 0);
    chk("b_y_487", y_b, 487);
`ifdef VLINE_BOUNCE_EN
    nx(); ng();
    chk("b_bounce_dw", {ib.UP, ib.DW}, 2'b01);
    chk("b_bounce_dir", ib.dir, 0);
    chk("b_bounce_cnt", ib.bounce_cnt, 1);
    nx(); ng();
    chk("b_bounce_y_486", y_b, 486);
    chk("b_bounce_done", {ib.UP, ib.DW}, 0);
    chk("b_bounce_moving", ib.moving, 1);
    nx(); ib.start = 1; ng();
    nx(); ib.start = 0; ng();
    chk("b_start_ignored_in_wait", ib.LD, 0);
`else
    nx(); ng();
    chk("b_parked_no_strobe", {ib.UP, ib.DW}, 0);
    chk("b_parked_not_moving", ib.moving, 0);
    chk("b_parked_dir_held", ib.dir, 1);
    chk("b_parked_bounce_0", ib.bounce_cnt, 0);
    nx(); ng();
    chk("b_parked_y_487", y_b, 487);
    for (int i = 0; i < 6; i++) begin
      nx(); ib.frame_tick = ~i[0]; ng();
      chk("b_parked_tick_no_strobe", {ib.UP, ib.DW}, 0);
    end
    nx(); ib.frame_tick = 0; ib.start = 1; ib.dir_in = 0; sw_b = 16'd200; ng();
    nx(); ib.start = 0; ng(); chk("b_unpark_ld", ib.LD, 1);
    nx(); ng();
    chk("b_unpark_y_200", y_b, 200);
    chk("b_unpark_dir_dw", ib.dir, 0);
    chk("b_unpark_moving", ib.moving, 1);
`endif

    // 5: halt during a STEP=8 burst after three UPs
    nx(); ic.start = 1; ic.dir_in = 1; sw_c = 16'd100; ng();
    nx(); ic.start = 0; ng(); chk("c_ld_pulse", ic.LD, 1);
    nx(); ng();
    nx(); ic.frame_tick = 1; ng();
    nx(); ic.frame_tick = 0; ng(); chk("c_up1", ic.UP, 1);
    nx(); ng(); chk("c_up2", ic.UP, 1);
    nx(); ng(); chk("c_up3", ic.UP, 1);
    nx(); ic.halt = 1; ng();
    chk("c_halt_no_strobe", {ic.UP, ic.DW}, 0);
    chk("c_halt_cycle_moving", ic.moving, 1);
    nx(); ic.halt = 0; ng();
    chk("c_halt_idle", ic.moving, 0);
    chk("c_halt_idle_strobe", {ic.UP, ic.DW}, 0);
    chk("c_y_103", y_c, 103);
    nx(); ic.start = 1; ic.dir_in = 0; sw_c = 16'd300; ng();
    chk("c_idle_no_ld", ic.LD, 0);
    nx(); ic.start = 0; ng(); chk("c_reload_ld", ic.LD, 1);
    nx(); ng();
    chk("c_y_300", y_c, 300);
    chk("c_dir_dw", ic.dir, 0);

    // 6: both limit flags during STEP
    nx(); ic.frame_tick = 1; ng();
    nx(); ic.frame_tick = 0; ng(); chk("c_dw1", {ic.UP, ic.DW}, 2'b01);
    nx(); frc_c = 1; ng(); chk("c_both_no_strobe", {ic.UP, ic.DW}, 0);
    nx(); frc_c = 0; ng();
    chk("c_both_parked", ic.moving, 0);
    chk("c_both_bounce_0", ic.bounce_cnt, 0);
    chk("c_y_299", y_c, 299);
    nx(); ic.frame_tick = 1; ng(); chk("c_parked_tick1", {ic.UP, ic.DW}, 0);
    nx(); ic.frame_tick = 0; ng(); chk("c_parked_tick2", {ic.UP, ic.DW}, 0);
    chk("c_parked_y", y_c, 299);

    // Random soak on the strobe invariants
    for (int i = 0; i < 300; i++) begin
      nx();
      ia.frame_tick = 1'($urandom_range(0, 1));
      ib.frame_tick = 1'($urandom_range(0, 1));
      ic.frame_tick = 1'($urandom_range(0, 1));
      ia.start = ($urandom_range(0, 7) == 0);
      ib.start = ($urandom_range(0, 7) == 0);
      ic.start = ($urandom_range(0, 7) == 0);
      ia.halt = ($urandom_range(0, 31) == 0);
      ib.halt = ($urandom_range(0, 31) == 0);
      ic.halt = ($urandom_range(0, 31) == 0);
      ia.dir_in = 1'($urandom_range(0, 1));
      ib.dir_in = 1'($urandom_range(0, 1));
      ic.dir_in = 1'($urandom_range(0, 1));
      sw_a = 16'($urandom_range(18, 487));
      sw_b = 16'($urandom_range(18, 487));
      sw_c = 16'($urandom_range(18, 487));
      ng();
      chk("soak_a_up_dw", ia.UP & ia.DW, 0);
      chk("soak_a_ld_strobe", ia.LD & (ia.UP | ia.DW), 0);
      chk("soak_b_up_dw", ib.UP & ib.DW, 0);
      chk("soak_b_ld_strobe", ib.LD & (ib.UP | ib.DW), 0);
      chk("soak_c_up_dw", ic.UP & ic.DW, 0);
      chk("soak_c_ld_strobe", ic.LD & (ic.UP | ic.DW), 0);
    end

    nx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
